// File: rtl/dec_4to16_pkg.sv
// Shared constants for the 4-to-16 decoder.
package dec_4to16_pkg;

  localparam int unsigned DEC_SEL_W = 4;
  localparam int unsigned DEC_OUT_W = 16;

  // Word presented when no decode is active, for each output polarity.
  localparam logic [DEC_OUT_W-1:0] DEC_INACTIVE_HIGH = 16'h0000;
  localparam logic [DEC_OUT_W-1:0] DEC_INACTIVE_LOW  = 16'hFFFF;

endpackage

// File: rtl/dec_2to4.sv
// Plain active-high 2-to-4 one-hot decoder with enable; building block for dec_4to16.
module dec_2to4 (
  input  logic [1:0] sel_i,
  input  logic       en_i,
  output logic [3:0] y_o
);

  // Raise the selected line only while enabled.
  always_comb begin
    y_o = 4'b0000;
    if (en_i) begin
      y_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/dec_4to16.sv
// 4-to-16 decoder built as a two-level tree of dec_2to4, with selectable output
// polarity and an optional output register.
module dec_4to16
  import dec_4to16_pkg::*;
#(
  parameter int unsigned OUT_ACTIVE_LOW = 0,
  parameter int unsigned REG_OUT        = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
  input  logic                 d,
  output logic [DEC_OUT_W-1:0] out,
  output logic                 out_valid
);

  localparam logic [DEC_OUT_W-1:0] Inactive =
      (OUT_ACTIVE_LOW != 0) ? DEC_INACTIVE_LOW : DEC_INACTIVE_HIGH;

  logic [3:0]           grp_en;
  logic [DEC_OUT_W-1:0] onehot;
  logic [DEC_OUT_W-1:0] word_d;

  // {a,b} picks one group of four; {c,d} picks the line within that group.
  dec_2to4 u_dec_hi (
    .sel_i ({a, b}),
    .en_i  (en),
    .y_o   (grp_en)
  );

  for (genvar g = 0; g < 4; g++) begin : gen_lo
    dec_2to4 u_dec_lo (
      .sel_i ({c, d}),
      .en_i  (grp_en[g]),
      .y_o   (onehot[g*4 +: 4])
    );
  end

  // Apply output polarity; a disabled tree is all-zero, which inverts to all-ones.
  always_comb begin
    word_d = onehot;
    if (OUT_ACTIVE_LOW != 0) begin
      word_d = ~onehot;
    end
  end

  if (REG_OUT != 0) begin : gen_reg
    logic [DEC_OUT_W-1:0] out_q;
    logic                 valid_q;

    // Output register; synchronous reset drops any in-flight decode.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_q   <= Inactive;
        valid_q <= 1'b0;
      end else begin
        out_q   <= word_d;
        valid_q <= en;
      end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
  end else begin : gen_comb
    // Combinational path; reset only suppresses the valid flag.
    assign out       = word_d;
    assign out_valid = en & rst_n;
  end

endmodule

// File: tb/tb_dec_4to16.sv
// Self-checking bench: registered active-high, registered active-low and
// combinational active-high decoders driven from shared inputs.
module tb_dec_4to16;

  logic        clk = 1'b0;
  logic        rst_n, en, a, b, c, d;
  logic [15:0] out_hi, out_lo, out_cb;
  logic        v_hi, v_lo, v_cb;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dec_4to16 #(.OUT_ACTIVE_LOW(0), .REG_OUT(1)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c), .d(d),
    .out(out_hi), .out_valid(v_hi)
  );

  dec_4to16 #(.OUT_ACTIVE_LOW(1), .REG_OUT(1)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c), .d(d),
    .out(out_lo), .out_valid(v_lo)
  );

  dec_4to16 #(.OUT_ACTIVE_LOW(0), .REG_OUT(0)) u_cb (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c), .d(d),
    .out(out_cb), .out_valid(v_cb)
  );

  // Reference: bit idx of a 16-bit word active when enabled, inverted for active-low.
  function automatic logic [15:0] model_word(input logic e, input int idx, input bit low);
    logic [15:0] w;
    w = e ? 16'(1 << idx) : 16'h0000;
    return low ? ~w : w;
  endfunction

  task automatic drive(input logic r, input logic e, input int idx);
    logic [3:0] s;
    s = 4'(idx);
    rst_n = r;
    en    = e;
    {a, b, c, d} = s;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b1, 5);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 4;
      if (out_hi !== 16'h0000) begin errors++; $display("FAIL reset_out_hi: got %h want 0000", out_hi); end
      if (v_hi !== 1'b0) begin errors++; $display("FAIL reset_valid_hi: got %b want 0", v_hi); end
      if (out_lo !== 16'hFFFF) begin errors++; $display("FAIL reset_out_lo: got %h want ffff", out_lo); end
      if (v_lo !== 1'b0) begin errors++; $display("FAIL reset_valid_lo: got %b want 0", v_lo); end
    end
  endtask

  task automatic test_sweep;
    for (int i = 0; i <= 16; i++) begin
      drive(1'b1, 1'b1, i % 16);
      tick();
      checks += 3;
      if (out_hi !== model_word(1'b1, i % 16, 1'b0)) begin
        errors++; $display("FAIL sweep_out_hi idx=%0d: got %h want %h", i % 16, out_hi, model_word(1'b1, i % 16, 1'b0));
      end
      if (v_hi !== 1'b1) begin errors++; $display("FAIL sweep_valid idx=%0d: got %b want 1", i % 16, v_hi); end
      if (out_lo !== model_word(1'b1, i % 16, 1'b1)) begin
        errors++; $display("FAIL sweep_out_lo idx=%0d: got %h want %h", i % 16, out_lo, model_word(1'b1, i % 16, 1'b1));
      end
    end
  endtask

  task automatic test_enable;
    drive(1'b1, 1'b0, 10);
    tick();
    checks += 3;
    if (out_hi !== 16'h0000) begin errors++; $display("FAIL enable_off_out: got %h want 0000", out_hi); end
    if (v_hi !== 1'b0) begin errors++; $display("FAIL enable_off_valid: got %b want 0", v_hi); end
    if (out_lo !== 16'hFFFF) begin errors++; $display("FAIL enable_off_out_lo: got %h want ffff", out_lo); end
    drive(1'b1, 1'b1, 10);
    tick();
    checks += 2;
    if (out_hi !== 16'h0400) begin errors++; $display("FAIL enable_on_out: got %h want 0400", out_hi); end
    if (v_hi !== 1'b1) begin errors++; $display("FAIL enable_on_valid: got %b want 1", v_hi); end
  endtask

  task automatic test_polarity;
    drive(1'b1, 1'b1, 3);
    tick();
    checks += 2;
    if (out_lo !== 16'hFFF7) begin errors++; $display("FAIL polarity_out: got %h want fff7", out_lo); end
    if (v_lo !== 1'b1) begin errors++; $display("FAIL polarity_valid: got %b want 1", v_lo); end
    drive(1'b0, 1'b1, 3);
    tick();
    checks += 1;
    if (out_lo !== 16'hFFFF) begin errors++; $display("FAIL polarity_reset: got %h want ffff", out_lo); end
  endtask

  task automatic test_midstream_reset;
    drive(1'b1, 1'b1, 6);
    tick();
    drive(1'b0, 1'b1, 7);
    tick();
    checks += 2;
    if (out_hi !== 16'h0000) begin errors++; $display("FAIL mid_reset_out: got %h want 0000", out_hi); end
    if (v_hi !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", v_hi); end
    drive(1'b1, 1'b1, 8);
    tick();
    checks += 2;
    if (out_hi !== 16'h0100) begin errors++; $display("FAIL mid_release_out: got %h want 0100", out_hi); end
    if (v_hi !== 1'b1) begin errors++; $display("FAIL mid_release_valid: got %b want 1", v_hi); end
  endtask

  task automatic test_comb;
    @(negedge clk);
    drive(1'b1, 1'b1, 15);
    #1;
    checks += 2;
    if (out_cb !== 16'h8000) begin errors++; $display("FAIL comb_out_15: got %h want 8000", out_cb); end
    if (v_cb !== 1'b1) begin errors++; $display("FAIL comb_valid: got %b want 1", v_cb); end
    drive(1'b1, 1'b1, 0);
    #1;
    checks += 1;
    if (out_cb !== 16'h0001) begin errors++; $display("FAIL comb_wrap: got %h want 0001", out_cb); end
    drive(1'b1, 1'b0, 0);
    #1;
    checks += 2;
    if (out_cb !== 16'h0000) begin errors++; $display("FAIL comb_disabled: got %h want 0000", out_cb); end
    if (v_cb !== 1'b0) begin errors++; $display("FAIL comb_disabled_valid: got %b want 1'b0", v_cb); end
  endtask

  task automatic test_random;
    logic        r, e;
    int          idx;
    logic [15:0] exp_hi, exp_lo;
    logic        exp_v;
    for (int n = 0; n < 300; n++) begin
      r   = ($urandom_range(0, 9) != 0);
      e   = ($urandom_range(0, 3) != 0);
      idx = int'($urandom_range(0, 15));
      drive(r, e, idx);
      #1;
      checks += 2;
      if (out_cb !== model_word(e, idx, 1'b0)) begin
        errors++; $display("FAIL rand_comb_out n=%0d: got %h want %h", n, out_cb, model_word(e, idx, 1'b0));
      end
      if (v_cb !== (r & e)) begin errors++; $display("FAIL rand_comb_valid n=%0d: got %b want %b", n, v_cb, r & e); end
      tick();
      exp_hi = r ? model_word(e, idx, 1'b0) : 16'h0000;
      exp_lo = r ? model_word(e, idx, 1'b1) : 16'hFFFF;
      exp_v  = r & e;
      checks += 4;
      if (out_hi !== exp_hi) begin errors++; $display("FAIL rand_out_hi n=%0d: got %h want %h", n, out_hi, exp_hi); end
      if (out_lo !== exp_lo) begin errors++; $display("FAIL rand_out_lo n=%0d: got %h want %h", n, out_lo, exp_lo); end
      if (v_hi !== exp_v) begin errors++; $display("FAIL rand_valid_hi n=%0d: got %b want %b", n, v_hi, exp_v); end
      if (v_lo !== exp_v) begin errors++; $display("FAIL rand_valid_lo n=%0d: got %b want %b", n, v_lo, exp_v); end
      if (v_hi === 1'b1) begin
        checks++;
        if ($countones(out_hi) != 1) begin
          errors++; $display("FAIL rand_onehot n=%0d: got %h want exactly one bit set", n, out_hi);
        end
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 0);
    tick();
    test_reset();
    test_sweep();
    test_enable();
    test_polarity();
    test_midstream_reset();
    test_comb();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
